input_conditioner: RTL and testbench



---
 rtl/input_cond_pkg.sv | 19 +
 rtl/input_conditioner_sync.sv | 20 ++
 rtl/input_conditioner.sv | 126 ++++++++++++
 tb/tb_input_conditioner.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and constants for the input_conditioner slice.
package input_cond_pkg;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  localparam int unsigned               BOUNCE_CNT_W   = 8;
  localparam logic [BOUNCE_CNT_W-1:0]   BOUNCE_CNT_MAX = 8'd255;

  // Width of a counter that must reach cycles-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_conditioner_sync.sv
// Plain flop-chain synchronizer, async active-high reset to 0.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_stage;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stage <= '0;
    else       r_stage <= {r_stage[STAGES-2:0], d};
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizer + debounce FSM + registered rise/fall pulses.
// Optional rejected-glitch counter enabled by INPUT_COND_BOUNCE_CNT_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_async,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse
`ifdef INPUT_COND_BOUNCE_CNT_EN
  ,
  output logic [BOUNCE_CNT_W-1:0] bounce_cnt
`endif
);

  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_sync;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dout, w_dout_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din_async),
    .q     (w_sync)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_STABLE_LO: begin
        if (w_sync) begin
          w_state_nxt = ST_WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_HI: begin
        if (!w_sync) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
          w_dout_nxt  = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_STABLE_HI: begin
        if (!w_sync) begin
          w_state_nxt = ST_WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LO: begin
        if (w_sync) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
          w_dout_nxt  = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_STABLE_LO;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign dout       = r_dout;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef INPUT_COND_BOUNCE_CNT_EN
  // Abort decoded from current state so the default build carries no unused net.
  logic                    w_abort;
  logic [BOUNCE_CNT_W-1:0] r_bounce;

  assign w_abort = ((r_state == ST_WAIT_HI) && !w_sync) ||
                   ((r_state == ST_WAIT_LO) &&  w_sync);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        r_bounce <= '0;
    else if (w_abort && (r_bounce != BOUNCE_CNT_MAX)) r_bounce <= r_bounce + 1'b1;
  end

  assign bounce_cnt = r_bounce;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: expected pulses queued by stimulus, checked by a monitor.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout, rise_pulse, fall_pulse;
`ifdef INPUT_COND_BOUNCE_CNT_EN
  logic [7:0] bounce_cnt;
`endif

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;

  typedef struct {
    bit rise;
    int at;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;
  bit  mdl_dout = 1'b0;
  int  c0;

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (rst),
    .din_async  (din),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
`ifdef INPUT_COND_BOUNCE_CNT_EN
    ,
    .bounce_cnt (bounce_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input bit rise, input int at);
    ev_t e;
    e.rise = rise;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic glitch(input int hi, input int lo);
    din = 1'b1;
    wait_cyc(hi);
    din = 1'b0;
    wait_cyc(lo);
  endtask

  task automatic chk_bounce(input string name, input int exp);
`ifdef INPUT_COND_BOUNCE_CNT_EN
    chk(name, 32'(bounce_cnt), exp);
`endif
  endtask

  // Monitor: every pulse must match the head of the queue; dout follows accepted events.
  always @(negedge clk) begin
    if (rst) begin
      mdl_dout = 1'b0;
      chk("dout_in_reset", 32'(dout), 0);
      chk("pulses_in_reset", {30'b0, rise_pulse, fall_pulse}, 0);
    end else begin
      if (rise_pulse || fall_pulse) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'b0, rise_pulse, fall_pulse}, 0);
        end else begin
          ev = exp_q.pop_front();
          chk("pulse_kind", {30'b0, rise_pulse, fall_pulse}, ev.rise ? 32'd2 : 32'd1);
          chk("pulse_cycle", cyc, ev.at);
          mdl_dout = ev.rise;
        end
      end
      chk("dout_level", 32'(dout), 32'(mdl_dout));
    end
  end

  initial begin
    rst = 1'b1;
    din = 1'b1;
    wait_cyc(1);
    chk("reset_dout", 32'(dout), 0);
    chk("reset_pulses", {30'b0, rise_pulse, fall_pulse}, 0);
    chk_bounce("reset_bounce", 0);

    // 1: release with input already high
    wait_cyc(19);
    rst = 1'b0;
    c0  = cyc;
    expect_pulse(1'b1, c0 + 7);
    wait_cyc(10);
    drain("t1_rise_seen");

    // 2: clean fall
    din = 1'b0;
    c0  = cyc;
    expect_pulse(1'b0, c0 + 7);
    wait_cyc(12);
    drain("t2_fall_seen");

    // 3: 3-cycle glitch rejected
    glitch(3, 5);
    wait_cyc(6);
    chk_bounce("t3_bounce", 1);

    // 4: bounce train then hold high
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(3);
    repeat (5) glitch(2, 2);
    din = 1'b1;
    c0  = cyc;
    expect_pulse(1'b1, c0 + 7);
    wait_cyc(10);
    drain("t4_single_rise");
    chk_bounce("t4_bounce", 5);

    // 4b: asynchronous clear from dout=1
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_dout", 32'(dout), 0);
    chk("async_pulses", {30'b0, rise_pulse, fall_pulse}, 0);
    chk_bounce("async_bounce", 0);
    wait_cyc(2);
    rst = 1'b0;
    c0  = cyc;
    expect_pulse(1'b1, c0 + 7);
    wait_cyc(10);
    drain("t4b_relatch");
    din = 1'b0;
    c0  = cyc;
    expect_pulse(1'b0, c0 + 7);
    wait_cyc(12);
    drain("t4b_fall");

    // 5: reset while WAIT_HI counter is at 2, glitch count non-zero
    glitch(2, 6);
    din = 1'b1;
    wait_cyc(5);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_dout", 32'(dout), 0);
    chk("t5_async_pulses", {30'b0, rise_pulse, fall_pulse}, 0);
    chk_bounce("t5_async_bounce", 0);
    wait_cyc(3);
    rst = 1'b0;
    c0  = cyc;
    expect_pulse(1'b1, c0 + 7);
    wait_cyc(10);
    drain("t5_full_latency");

    // 6: glitch counter saturation
    din = 1'b0;
    c0  = cyc;
    expect_pulse(1'b0, c0 + 7);
    wait_cyc(12);
    drain("t6_fall");
    repeat (254) glitch(2, 2);
    wait_cyc(6);
    chk_bounce("t6_bounce_254", 254);
    glitch(2, 2);
    wait_cyc(6);
    chk_bounce("t6_bounce_255", 255);
    repeat (45) glitch(2, 2);
    wait_cyc(6);
    chk_bounce("t6_bounce_hold", 255);

    drain("final_queue_empty");
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
